// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - stall/flush/forwarding control for the 5-stage RV32 pipeline
// Tracks E/M/W register tags internally and counts load-use bubbles and redirect flushes.
module hazard_ctrl #(
  parameter int CNT_W  = 16,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] Rs1D,
  input  logic [ADDR_W-1:0] Rs2D,
  input  logic [ADDR_W-1:0] RdD,
  input  logic              RegWriteD,
  input  logic [1:0]        ResultSrcD,
  input  logic              PCSrcE,
  output logic              StallF,
  output logic              StallD,
  output logic              FlushD,
  output logic              FlushE,
  output logic [1:0]        ForwardAE,
  output logic [1:0]        ForwardBE,
  output logic [CNT_W-1:0]  LoadStallCnt,
  output logic [CNT_W-1:0]  FlushCnt
);
  logic [ADDR_W-1:0] rs1_e, rs2_e, rd_e, rd_m, rd_w;
  logic              reg_write_e, reg_write_m, reg_write_w, load_e;
  logic              lw_stall;

  // rs2 match is deliberately unqualified: a spurious stall is cheaper than decoding operand use
  assign lw_stall = load_e && (rd_e != '0) && ((rd_e == Rs1D) || (rd_e == Rs2D));

  // A redirect kills the stalled decode instruction, so it overrides the stall
  assign StallF = lw_stall && !PCSrcE;
  assign StallD = lw_stall && !PCSrcE;
  assign FlushD = PCSrcE;
  assign FlushE = lw_stall || PCSrcE;

  always_comb begin
    ForwardAE = 2'b00;
    if (reg_write_m && (rd_m != '0) && (rd_m == rs1_e))
      ForwardAE = 2'b10;
    else if (reg_write_w && (rd_w != '0) && (rd_w == rs1_e))
      ForwardAE = 2'b01;
  end

  always_comb begin
    ForwardBE = 2'b00;
    if (reg_write_m && (rd_m != '0) && (rd_m == rs2_e))
      ForwardBE = 2'b10;
    else if (reg_write_w && (rd_w != '0) && (rd_w == rs2_e))
      ForwardBE = 2'b01;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rs1_e        <= '0;
      rs2_e        <= '0;
      rd_e         <= '0;
      reg_write_e  <= 1'b0;
      load_e       <= 1'b0;
      rd_m         <= '0;
      reg_write_m  <= 1'b0;
      rd_w         <= '0;
      reg_write_w  <= 1'b0;
      LoadStallCnt <= '0;
      FlushCnt     <= '0;
    end else begin
      if (FlushE) begin
        rs1_e       <= '0;
        rs2_e       <= '0;
        rd_e        <= '0;
        reg_write_e <= 1'b0;
        load_e      <= 1'b0;
      end else begin
        rs1_e       <= Rs1D;
        rs2_e       <= Rs2D;
        rd_e        <= RdD;
        reg_write_e <= RegWriteD;
        load_e      <= (ResultSrcD == 2'b01);
      end
      rd_m        <= rd_e;
      reg_write_m <= reg_write_e;
      rd_w        <= rd_m;
      reg_write_w <= reg_write_m;

      if (lw_stall && !PCSrcE && (LoadStallCnt != '1))
        LoadStallCnt <= LoadStallCnt + CNT_W'(1);
      if (PCSrcE && (FlushCnt != '1))
        FlushCnt <= FlushCnt + CNT_W'(1);
    end
  end
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - directed checks of hazard_ctrl with 4-bit counters
module tb_hazard_ctrl;
  logic       clk = 1'b0;
  logic       reset_n;
  logic [4:0] Rs1D, Rs2D, RdD;
  logic       RegWriteD;
  logic [1:0] ResultSrcD;
  logic       PCSrcE;
  logic       StallF, StallD, FlushD, FlushE;
  logic [1:0] ForwardAE, ForwardBE;
  logic [3:0] LoadStallCnt, FlushCnt;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  hazard_ctrl #(.CNT_W(4), .ADDR_W(5)) dut (
    .clk(clk), .reset_n(reset_n),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .RdD(RdD), .RegWriteD(RegWriteD),
    .ResultSrcD(ResultSrcD), .PCSrcE(PCSrcE),
    .StallF(StallF), .StallD(StallD), .FlushD(FlushD), .FlushE(FlushE),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .LoadStallCnt(LoadStallCnt), .FlushCnt(FlushCnt)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Decode-stage instruction plus redirect flag, then let combinational outputs settle
  task automatic setd(input int rs1, input int rs2, input int rd, input bit rw,
                      input int src, input bit pc);
    Rs1D = 5'(rs1); Rs2D = 5'(rs2); RdD = 5'(rd);
    RegWriteD = rw; ResultSrcD = 2'(src); PCSrcE = pc;
    #1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_ctl(input string tag, input bit sf, input bit sd, input bit fd, input bit fe);
    chk({tag, "_StallF"}, int'(StallF), int'(sf));
    chk({tag, "_StallD"}, int'(StallD), int'(sd));
    chk({tag, "_FlushD"}, int'(FlushD), int'(fd));
    chk({tag, "_FlushE"}, int'(FlushE), int'(fe));
  endtask

  initial begin
    reset_n = 1'b0;
    setd(0, 0, 0, 0, 0, 0);
    step(); step();
    chk_ctl("rst", 0, 0, 0, 0);
    chk("rst_FwdA", int'(ForwardAE), 0);
    chk("rst_FwdB", int'(ForwardBE), 0);
    chk("rst_LdCnt", int'(LoadStallCnt), 0);
    chk("rst_FlCnt", int'(FlushCnt), 0);
    reset_n = 1'b1;

    // add x5 ; add x6,x5,x5 -> forward from M
    setd(0, 0, 5, 1, 0, 0); step();
    setd(5, 5, 6, 1, 0, 0); step();
    setd(0, 0, 0, 0, 0, 0);
    chk("m_FwdA", int'(ForwardAE), 2);
    chk("m_FwdB", int'(ForwardBE), 2);
    chk_ctl("m", 0, 0, 0, 0);

    // add x9 ; nop ; add x10,x9,x9 -> forward from W
    setd(0, 0, 9, 1, 0, 0); step();
    setd(0, 0, 0, 0, 0, 0); step();
    setd(9, 9, 10, 1, 0, 0); step();
    setd(0, 0, 0, 0, 0, 0);
    chk("w_FwdA", int'(ForwardAE), 1);
    chk("w_FwdB", int'(ForwardBE), 1);

    // M and W both write x5 -> M wins
    setd(0, 0, 5, 1, 0, 0); step();
    setd(0, 0, 5, 1, 0, 0); step();
    setd(5, 0, 11, 1, 0, 0); step();
    setd(0, 0, 0, 0, 0, 0);
    chk("mw_FwdA", int'(ForwardAE), 2);
    chk("mw_FwdB", int'(ForwardBE), 0);

    // x0 producer never forwards
    setd(0, 0, 0, 1, 0, 0); step();
    setd(0, 0, 12, 1, 0, 0); step();
    setd(0, 0, 0, 0, 0, 0);
    chk("x0_FwdA", int'(ForwardAE), 0);
    chk("x0_FwdB", int'(ForwardBE), 0);

    // lw x7 ; add x8,x7,x1 -> one bubble, then forward from W
    setd(1, 0, 7, 1, 1, 0); step();
    setd(7, 1, 8, 1, 0, 0);
    chk_ctl("lu", 1, 1, 0, 1);
    chk("lu_LdCnt0", int'(LoadStallCnt), 0);
    step();
    chk_ctl("lu_next", 0, 0, 0, 0);
    chk("lu_LdCnt1", int'(LoadStallCnt), 1);
    chk("lu_bub_FwdA", int'(ForwardAE), 0);
    step();
    setd(0, 0, 0, 0, 0, 0);
    chk("lu_FwdA", int'(ForwardAE), 1);
    chk("lu_FwdB", int'(ForwardBE), 0);

    // redirect while add x13 is in E; the x14 instruction in D becomes a bubble
    setd(0, 0, 13, 1, 0, 0); step();
    setd(0, 0, 14, 1, 0, 1);
    chk_ctl("rd", 0, 0, 1, 1);
    chk("rd_FlCnt0", int'(FlushCnt), 0);
    step();
    setd(14, 13, 15, 1, 0, 0);
    chk("rd_FlCnt1", int'(FlushCnt), 1);
    step();
    setd(0, 0, 0, 0, 0, 0);
    chk("rd_bub_FwdA", int'(ForwardAE), 0);
    chk("rd_bub_FwdB", int'(ForwardBE), 1);

    // load-use and redirect together: redirect wins
    setd(0, 0, 16, 1, 1, 0); step();
    setd(16, 0, 17, 1, 0, 1);
    chk_ctl("sim", 0, 0, 1, 1);
    step();
    setd(0, 0, 0, 0, 0, 0);
    chk("sim_FlCnt", int'(FlushCnt), 2);
    chk("sim_LdCnt", int'(LoadStallCnt), 1);

    // asynchronous reset drops in-flight tags
    setd(0, 0, 5, 1, 0, 0); step();
    setd(5, 0, 0, 0, 0, 0); step();
    chk("pre_rst_FwdA", int'(ForwardAE), 2);
    reset_n = 1'b0;
    #1;
    chk("arst_FwdA", int'(ForwardAE), 0);
    chk("arst_LdCnt", int'(LoadStallCnt), 0);
    chk("arst_FlCnt", int'(FlushCnt), 0);
    step();
    reset_n = 1'b1;
    #1;
    chk("post_rst_FwdA0", int'(ForwardAE), 0);
    step();
    setd(0, 0, 0, 0, 0, 0);
    chk("post_rst_FwdA1", int'(ForwardAE), 0);
    step();
    chk("post_rst_FwdA2", int'(ForwardAE), 0);

    // 20 redirects into a 4-bit counter saturate at 15
    setd(0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 20; i++) begin
      chk($sformatf("sat_FlCnt_%0d", i), int'(FlushCnt), (i < 15) ? i : 15);
      step();
    end
    setd(0, 0, 0, 0, 0, 0);
    chk("sat_FlCnt_end", int'(FlushCnt), 15);
    step();
    chk("sat_FlCnt_hold", int'(FlushCnt), 15);
    chk("sat_LdCnt", int'(LoadStallCnt), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Pipeline hazard controller for the 5-stage RV32 core.
- Generates the stall and flush controls for the fetch and decode registers. Generates the `FlushE` clear that drives the ID/EX control register.
- Generates the EX-stage forwarding selects.
- Keeps its own shadow pipeline of destination/source register tags and write-enables for the E, M and W stages. It also keeps saturating hazard event counters for performance monitoring.

Parameters:
- `CNT_W`, 16, width of each saturating event counter.
- `ADDR_W`, 5, register index width.

Ports:
- `clk` input 1: core clock; all state updates on the rising edge.
- `reset_n` input 1: asynchronous active-low reset.
- `Rs1D` input `ADDR_W`: rs1 of the instruction in decode.
- `Rs2D` input `ADDR_W`: rs2 of the instruction in decode.
- `RdD` input `ADDR_W`: rd of the instruction in decode.
- `RegWriteD` input 1: decode-stage register write enable.
- `ResultSrcD` input 2: decode-stage result select; 2'b01 = load.
- `PCSrcE` input 1: branch taken / jump resolved in E (redirect).
- `StallF` output 1: hold PC register.
- `StallD` output 1: hold IF/ID register.
- `FlushD` output 1: clear IF/ID register.
- `FlushE` output 1: clear ID/EX registers (control and data).
- `ForwardAE` output 2: ALU operand A select; 00 = regfile, 01 = ResultW, 10 = ALUResultM.
- `ForwardBE` output 2: ALU operand B select; same encoding as `ForwardAE`.
- `LoadStallCnt` output `CNT_W`: count of load-use bubbles inserted.
- `FlushCnt` output `CNT_W`: count of redirect flushes.

Behaviour:
- **Reset:** `reset_n` low asynchronously clears all shadow state (tags = 0, write-enables = 0, load flag = 0) and both counters = 0. Outputs are combinational, so with reset held they evaluate to all-zero (`Forward*E` = 00, `Stall*`/`Flush*` = 0). Reset mid-operation discards all in-flight tags; no hazard is reported for pre-reset instructions.
- **Shadow pipeline (per rising edge):**
  - E-stage shadow {Rs1E, Rs2E, RdE, RegWriteE, LoadE} <= decode inputs, with LoadE = (ResultSrcD == 2'b01).
  - If `FlushE` = 1 this cycle, the E-stage shadow instead loads a bubble: all fields 0.
  - M-stage shadow {RdM, RegWriteM} <= {RdE, RegWriteE}.
  - W-stage shadow {RdW, RegWriteW} <= {RdM, RegWriteM}.
  - M and W never stall.
- **Forwarding (combinational, 0-cycle):**
  - `ForwardAE` = 10 if RegWriteM && RdM != 0 && RdM == Rs1E.
  - Else `ForwardAE` = 01 if RegWriteW && RdW != 0 && RdW == Rs1W-match, i.e. RdW == Rs1E.
  - Else `ForwardAE` = 00.
  - M has priority over W. `ForwardBE` is identical using Rs2E.
  - x0 never forwards.
- **Load-use hazard:** lwStall = LoadE && RdE != 0 && (RdE == Rs1D || RdE == Rs2D). The check is not qualified by whether the D instruction actually reads rs2.
- **Output equations:**
  - `StallF` = `StallD` = lwStall && !PCSrcE.
  - `FlushD` = PCSrcE.
  - `FlushE` = lwStall || PCSrcE.
- **Simultaneous lwStall and PCSrcE:** the redirect wins. No stall; D and E are both flushed, because the stalled D instruction is on the wrong path.
- **Bubble sequence:** a load-use stall produces exactly one bubble. Next cycle the load is in M, LoadE = 0, and forwarding from M is not used for the load because the dependent instruction reaches E one cycle later. The dependent instruction then forwards from W (01).
- **Counters:**
  - `LoadStallCnt` increments on each cycle where lwStall && !PCSrcE.
  - `FlushCnt` increments on each cycle where PCSrcE = 1.
  - Both saturate at all-ones and never wrap.
  - Both are registered; the value is visible the cycle after the event.

Test Plan:
- **Reset:** assert `reset_n` = 0 mid-stream with RegWriteM = 1, RdM = 5 previously loaded, Rs1E = 5 -> immediately `ForwardAE` = 00, counters = 0; after release no forwarding until new tags propagate.
- **M/W forwarding:**
  - Sequence `add x5`, `add x6,x5,x5` -> in second's E cycle `ForwardAE` = `ForwardBE` = 10.
  - With one independent instruction between them -> 01.
  - Both M and W write x5 -> 10.
  - rd = x0 producer -> 00.
- **Load-use:**
  - `lw x7` then `add x8,x7,x1` -> one cycle with `StallF` = `StallD` = `FlushE` = 1, `LoadStallCnt` 0 -> 1 next cycle.
  - Next cycle all stall/flush outputs = 0.
  - The add in E then sees `ForwardAE` = 01.
- **Redirect flush:** PCSrcE = 1 for one cycle -> `FlushD` = `FlushE` = 1, `Stall*` = 0, `FlushCnt` +1.
  - The E shadow loads a bubble: following cycle RegWriteM tag = 0, so no forwarding from it.
- **Simultaneous:** lwStall condition and PCSrcE = 1 in the same cycle -> `StallF` = `StallD` = 0, `FlushD` = `FlushE` = 1, `FlushCnt` +1, `LoadStallCnt` unchanged.
- **Saturation:** with `CNT_W` = 4, drive 20 redirect cycles -> `FlushCnt` reaches 15 and holds at 15.
